// File: rtl/fifo_banco_pkg.sv
// Shared sizing for the multi-channel FIFO bank.
// Channel count, depth, word width and derived pointer/count widths.
package fifo_banco_pkg;
  localparam int NUM_CH    = 4;
  localparam int MEM_SIZE  = 8;
  localparam int WORD_SIZE = 6;
  localparam int PTR_L     = $clog2(MEM_SIZE);
  localparam int CH_L      = $clog2(NUM_CH);
  localparam int CNT_W     = PTR_L + 1;
endpackage

// File: rtl/fifo_canal.sv
// Single-channel FIFO: pointers, occupancy count, status flags and
// a sticky overflow/underflow error bit.
module fifo_canal
  import fifo_banco_pkg::*;
#(
  parameter int MEM_SIZE  = fifo_banco_pkg::MEM_SIZE,
  parameter int WORD_SIZE = fifo_banco_pkg::WORD_SIZE,
  parameter int PTR_L     = $clog2(MEM_SIZE)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic                 rd_en,
  input  logic [WORD_SIZE-1:0] din,
  input  logic [PTR_L:0]       empty_thr,
  input  logic [PTR_L:0]       full_thr,
  output logic [WORD_SIZE-1:0] dout,
  output logic                 rd_ok,
  output logic                 empty,
  output logic                 full,
  output logic                 almost_empty,
  output logic                 almost_full,
  output logic                 error
);
  localparam logic [PTR_L:0] FULL_CNT = (PTR_L+1)'(MEM_SIZE);

  logic [PTR_L-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_L-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PTR_L:0]       count_q, count_d;
  logic                 error_q, error_d;
  logic                 wr_ok;
  logic [WORD_SIZE-1:0] mem_q [MEM_SIZE];

  assign empty        = (count_q == '0);
  assign full         = (count_q == FULL_CNT);
  assign almost_empty = (count_q <= empty_thr);
  assign almost_full  = (count_q >= full_thr);
  assign error        = error_q;
  assign dout         = mem_q[rd_ptr_q];

  // A read on a full channel frees the slot the write lands in.
  assign rd_ok = rd_en && !empty;
  assign wr_ok = wr_en && (!full || rd_en);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    error_d  = error_q | (wr_en & ~wr_ok) | (rd_en & ~rd_ok);
    if (wr_ok) wr_ptr_d = wr_ptr_q + PTR_L'(1);
    if (rd_ok) rd_ptr_d = rd_ptr_q + PTR_L'(1);
    unique case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + (PTR_L+1)'(1);
      2'b01:   count_d = count_q - (PTR_L+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      error_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      error_q  <= error_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && wr_ok) mem_q[wr_ptr_q] <= din;
  end
endmodule

// File: rtl/fifo_banco_canales.sv
// Bank of independent FIFOs behind one write port and one read port,
// with a registered read-data stage and valid strobe.
module fifo_banco_canales
  import fifo_banco_pkg::*;
#(
  parameter int NUM_CH    = fifo_banco_pkg::NUM_CH,
  parameter int MEM_SIZE  = fifo_banco_pkg::MEM_SIZE,
  parameter int WORD_SIZE = fifo_banco_pkg::WORD_SIZE,
  parameter int PTR_L     = $clog2(MEM_SIZE),
  parameter int CH_L      = $clog2(NUM_CH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WORD_SIZE-1:0] fifo_data_in,
  input  logic                 fifo_wr,
  input  logic [CH_L-1:0]      wr_ch,
  input  logic                 fifo_rd,
  input  logic [CH_L-1:0]      rd_ch,
  input  logic [PTR_L:0]       empty_threshold,
  input  logic [PTR_L:0]       full_threshold,
  output logic [WORD_SIZE-1:0] fifo_data_out,
  output logic                 valid_out,
  output logic [NUM_CH-1:0]    fifo_empty,
  output logic [NUM_CH-1:0]    fifo_full,
  output logic [NUM_CH-1:0]    almost_empty,
  output logic [NUM_CH-1:0]    almost_full,
  output logic [NUM_CH-1:0]    error
);
  logic [NUM_CH-1:0]    wr_sel, rd_sel, rd_ok;
  logic [WORD_SIZE-1:0] rd_data [NUM_CH];
  logic [WORD_SIZE-1:0] data_q, data_d;
  logic                 valid_q, valid_d;

  always_comb begin
    wr_sel = '0;
    rd_sel = '0;
    if (fifo_wr) wr_sel[wr_ch] = 1'b1;
    if (fifo_rd) rd_sel[rd_ch] = 1'b1;
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    fifo_canal #(
      .MEM_SIZE (MEM_SIZE),
      .WORD_SIZE(WORD_SIZE),
      .PTR_L    (PTR_L)
    ) u_canal (
      .clk         (clk),
      .reset       (reset),
      .wr_en       (wr_sel[c]),
      .rd_en       (rd_sel[c]),
      .din         (fifo_data_in),
      .empty_thr   (empty_threshold),
      .full_thr    (full_threshold),
      .dout        (rd_data[c]),
      .rd_ok       (rd_ok[c]),
      .empty       (fifo_empty[c]),
      .full        (fifo_full[c]),
      .almost_empty(almost_empty[c]),
      .almost_full (almost_full[c]),
      .error       (error[c])
    );
  end

  // Only the selected channel can report an accepted read.
  always_comb begin
    valid_d = |rd_ok;
    data_d  = valid_d ? rd_data[rd_ch] : data_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign fifo_data_out = data_q;
  assign valid_out     = valid_q;
endmodule

// File: tb/tb_fifo_banco_canales.sv
// Self-checking bench for fifo_banco_canales against per-channel queues.
// Directed scenarios followed by a randomized phase.
module tb_fifo_banco_canales;
  localparam int NCH = 4;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] fifo_data_in;
  logic       fifo_wr, fifo_rd;
  logic [1:0] wr_ch, rd_ch;
  logic [3:0] empty_threshold, full_threshold;
  logic [5:0] fifo_data_out;
  logic       valid_out;
  logic [3:0] fifo_empty, fifo_full, almost_empty, almost_full, error;

  int checks = 0;
  int errors = 0;

  int         q [NCH][$];
  bit [3:0]   m_err;
  logic [5:0] m_data;
  bit         m_valid;

  always #5 clk = ~clk;

  fifo_banco_canales dut (
    .clk            (clk),
    .reset          (reset),
    .fifo_data_in   (fifo_data_in),
    .fifo_wr        (fifo_wr),
    .wr_ch          (wr_ch),
    .fifo_rd        (fifo_rd),
    .rd_ch          (rd_ch),
    .empty_threshold(empty_threshold),
    .full_threshold (full_threshold),
    .fifo_data_out  (fifo_data_out),
    .valid_out      (valid_out),
    .fifo_empty     (fifo_empty),
    .fifo_full      (fifo_full),
    .almost_empty   (almost_empty),
    .almost_full    (almost_full),
    .error          (error)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int c = 0; c < NCH; c++) begin
      int n;
      n = q[c].size();
      chk($sformatf("empty[%0d]", c), 32'(fifo_empty[c]), 32'(n == 0));
      chk($sformatf("full[%0d]", c), 32'(fifo_full[c]), 32'(n == DEPTH));
      chk($sformatf("aempty[%0d]", c), 32'(almost_empty[c]),
          32'(n <= int'(empty_threshold)));
      chk($sformatf("afull[%0d]", c), 32'(almost_full[c]),
          32'(n >= int'(full_threshold)));
      chk($sformatf("error[%0d]", c), 32'(error[c]), 32'(m_err[c]));
    end
    chk("valid_out", 32'(valid_out), 32'(m_valid));
    chk("data_out", 32'(fifo_data_out), 32'(m_data));
  endtask

  task automatic step(input bit rst, input bit w, input int wc,
                      input logic [5:0] d, input bit r, input int rc);
    reset        = rst;
    fifo_wr      = w;
    wr_ch        = wc[1:0];
    fifo_data_in = d;
    fifo_rd      = r;
    rd_ch        = rc[1:0];
    @(posedge clk);
    if (rst) begin
      for (int c = 0; c < NCH; c++) q[c].delete();
      m_err   = '0;
      m_valid = 1'b0;
      m_data  = '0;
    end else begin
      m_valid = 1'b0;
      if (r) begin
        if (q[rc].size() > 0) begin
          m_data  = 6'(q[rc].pop_front());
          m_valid = 1'b1;
        end else begin
          m_err[rc] = 1'b1;
        end
      end
      if (w) begin
        if (q[wc].size() < DEPTH) q[wc].push_back(int'(d));
        else m_err[wc] = 1'b1;
      end
    end
    #1;
    check_all();
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 0, 6'h0, 1'b0, 0);
  endtask

  initial begin
    empty_threshold = 4'd1;
    full_threshold  = 4'd7;
    reset = 1'b1;
    fifo_wr = 1'b0;
    fifo_rd = 1'b0;
    wr_ch = '0;
    rd_ch = '0;
    fifo_data_in = '0;

    for (int i = 0; i < 3; i++) step(1'b1, 0, 0, 6'h0, 0, 0);
    chk("rst_empty", 32'(fifo_empty), 32'h0000_000f);
    chk("rst_aempty", 32'(almost_empty), 32'h0000_000f);
    idle();

    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 1'b1, 2, 6'(i), 1'b0, 0);
      if (i == 7) chk("ch2_afull_at7", 32'(almost_full[2]), 32'h1);
    end
    chk("ch2_full", 32'(fifo_full[2]), 32'h1);
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 1'b0, 0, 6'h0, 1'b1, 2);
      chk("ch2_order", 32'(fifo_data_out), 32'(i));
    end
    idle();

    for (int i = 0; i < 9; i++)
      step(1'b0, 1'b1, 1, 6'($urandom_range(63)), 1'b0, 0);
    chk("ch1_ovf", 32'(error), 32'h0000_0002);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 0, 6'h0, 1'b1, 1);
    chk("ch1_err_sticky", 32'(error), 32'h0000_0002);

    step(1'b0, 1'b0, 0, 6'h0, 1'b1, 3);
    chk("ch3_udf", 32'(error[3]), 32'h1);

    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 0, 6'(8'h20 + i), 1'b0, 0);
    step(1'b0, 1'b1, 0, 6'h3f, 1'b1, 0);
    chk("ch0_full_rdwr", 32'(fifo_full[0]), 32'h1);
    chk("ch0_full_noerr", 32'(error[0]), 32'h0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 0, 6'h0, 1'b1, 0);
    step(1'b0, 1'b1, 0, 6'h15, 1'b1, 0);
    chk("ch0_empty_rdwr_err", 32'(error[0]), 32'h1);
    chk("ch0_cnt1", 32'(fifo_empty[0]), 32'h0);
    step(1'b0, 1'b0, 0, 6'h0, 1'b1, 0);

    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1, 6'(i + 9), 1'b0, 0);
    for (int i = 0; i < 20; i++)
      step(i == 10, 1'b1, 0, 6'($urandom_range(63)), 1'b1, 1);
    step(1'b1, 0, 0, 6'h0, 0, 0);
    chk("post_rst_empty", 32'(fifo_empty), 32'h0000_000f);
    step(1'b0, 1'b0, 0, 6'h0, 1'b1, 0);
    chk("post_rst_rd", 32'(valid_out), 32'h0);

    for (int i = 0; i < 600; i++) begin
      if (i % 16 == 0) begin
        empty_threshold = 4'($urandom_range(15));
        full_threshold  = 4'($urandom_range(15));
        #1;
        check_all();
      end
      step($urandom_range(59) == 0,
           $urandom_range(2) != 0, int'($urandom_range(3)),
           6'($urandom_range(63)),
           $urandom_range(2) != 0, int'($urandom_range(3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
